// File: rtl/adc_responder_pkg.sv
// Shared types and constants for the emulated LTC2308-style ADC responder.
package adc_responder_pkg;

  localparam int unsigned CFG_BITS    = 6;
  localparam int unsigned RESULT_BITS = 12;
  localparam int unsigned CH_BITS     = 3;
  localparam int unsigned BIT_CNT_W   = 4;
  localparam int unsigned RAMP_COUNT  = 8;

  // Config word bit positions {SD,OS,S1,S0,UNI,SLP}
  localparam int unsigned CFG_SD  = 5;
  localparam int unsigned CFG_OS  = 4;
  localparam int unsigned CFG_S1  = 3;
  localparam int unsigned CFG_S0  = 2;
  localparam int unsigned CFG_UNI = 1;
  localparam int unsigned CFG_SLP = 0;

  typedef enum logic {
    READY = 1'b0,
    CONV  = 1'b1
  } state_e;

  // Unipolar keeps offset binary; bipolar flips the MSB into two's complement.
  function automatic logic [RESULT_BITS-1:0] code_of(input logic [RESULT_BITS-1:0] sample,
                                                     input logic uni);
    return uni ? sample : (sample ^ RESULT_BITS'(12'h800));
  endfunction

endpackage

// File: rtl/adc_responder_spi_edge_sync.sv
// Synchronizer chain plus history flop producing single-cycle rise/fall pulses.
module spi_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise_c,
  output logic o_fall_c
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic                   w_level;

  assign w_level = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
      r_hist <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_hist <= w_level;
    end
  end

  assign o_rise_c = w_level & ~r_hist;
  assign o_fall_c = ~w_level & r_hist;

endmodule

// File: rtl/adc_responder.sv
// Responder end of the 4-wire serial ADC link: shifts in config, shifts out the
// previous result, then models a conversion. Define ADC_RAMP_GEN_EN for internal ramps.
module adc_responder
  import adc_responder_pkg::*;
#(
  parameter int unsigned CONV_CYCLES = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   adc_cs_n,
  input  logic                   adc_sclk,
  input  logic                   adc_din,
  output logic                   adc_dout,
  output logic                   sample_req,
  output logic [CH_BITS-1:0]     sample_ch,
  input  logic [RESULT_BITS-1:0] sample_in,
  input  logic                   sample_valid,
  output logic [CFG_BITS-1:0]    cfg_word,
  output logic                   cfg_valid,
  output logic                   frame_err
);

  localparam int unsigned CNT_W = $clog2(CONV_CYCLES);

  // Reset: asynchronous assert, synchronous release
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  logic w_cs_rise, w_cs_fall, w_sclk_rise, w_sclk_fall;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk      (clk),
    .rst_n    (w_rst_n),
    .i_async  (adc_cs_n),
    .o_rise_c (w_cs_rise),
    .o_fall_c (w_cs_fall)
  );

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk      (clk),
    .rst_n    (w_rst_n),
    .i_async  (adc_sclk),
    .o_rise_c (w_sclk_rise),
    .o_fall_c (w_sclk_fall)
  );

  // din needs no edges, only the same latency as sclk
  logic [SYNC_STAGES-1:0] r_din_sync;
  logic                   w_din;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) r_din_sync <= '0;
    else          r_din_sync <= {r_din_sync[SYNC_STAGES-2:0], adc_din};
  end
  assign w_din = r_din_sync[SYNC_STAGES-1];

  state_e                 r_state, w_state_nxt;
  logic                   r_in_frame, w_in_frame_nxt;
  logic                   r_stale, w_stale_nxt;
  logic [BIT_CNT_W-1:0]   r_bit_cnt, w_bit_cnt_nxt;
  logic [CFG_BITS-1:0]    r_cfg_sr, w_cfg_sr_nxt;
  logic [RESULT_BITS-1:0] r_out_sr, w_out_sr_nxt;
  logic [RESULT_BITS-1:0] r_result, w_result_nxt;
  logic [RESULT_BITS-1:0] r_cap, w_cap_nxt;
  logic                   r_captured, w_captured_nxt;
  logic [CNT_W-1:0]       r_conv_cnt, w_conv_cnt_nxt;
  logic                   r_sample_req, w_sample_req_nxt;
  logic [CH_BITS-1:0]     r_sample_ch, w_sample_ch_nxt;
  logic [CFG_BITS-1:0]    r_cfg_word, w_cfg_word_nxt;
  logic                   r_cfg_valid, w_cfg_valid_nxt;
  logic                   r_frame_err, w_frame_err_nxt;
  logic                   r_dout, w_dout_nxt;
  logic [CH_BITS-1:0]     w_ch;

  assign w_ch = r_cfg_sr[CFG_OS:CFG_S0];

`ifdef ADC_RAMP_GEN_EN
  logic [RESULT_BITS-1:0] r_ramp [RAMP_COUNT];
  logic [RESULT_BITS-1:0] w_ramp_nxt [RAMP_COUNT];
  logic                   w_unused_sample;

  assign w_unused_sample = ^{sample_in, sample_valid};
`endif

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state      <= READY;
      r_in_frame   <= 1'b0;
      r_stale      <= 1'b0;
      r_bit_cnt    <= '0;
      r_cfg_sr     <= '0;
      r_out_sr     <= '0;
      r_result     <= '0;
      r_cap        <= '0;
      r_captured   <= 1'b0;
      r_conv_cnt   <= '0;
      r_sample_req <= 1'b0;
      r_sample_ch  <= '0;
      r_cfg_word   <= '0;
      r_cfg_valid  <= 1'b0;
      r_frame_err  <= 1'b0;
      r_dout       <= 1'b0;
`ifdef ADC_RAMP_GEN_EN
      for (int i = 0; i < int'(RAMP_COUNT); i++) r_ramp[i] <= '0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_in_frame   <= w_in_frame_nxt;
      r_stale      <= w_stale_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_cfg_sr     <= w_cfg_sr_nxt;
      r_out_sr     <= w_out_sr_nxt;
      r_result     <= w_result_nxt;
      r_cap        <= w_cap_nxt;
      r_captured   <= w_captured_nxt;
      r_conv_cnt   <= w_conv_cnt_nxt;
      r_sample_req <= w_sample_req_nxt;
      r_sample_ch  <= w_sample_ch_nxt;
      r_cfg_word   <= w_cfg_word_nxt;
      r_cfg_valid  <= w_cfg_valid_nxt;
      r_frame_err  <= w_frame_err_nxt;
      r_dout       <= w_dout_nxt;
`ifdef ADC_RAMP_GEN_EN
      for (int i = 0; i < int'(RAMP_COUNT); i++) r_ramp[i] <= w_ramp_nxt[i];
`endif
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_in_frame_nxt   = r_in_frame;
    w_stale_nxt      = r_stale;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_cfg_sr_nxt     = r_cfg_sr;
    w_out_sr_nxt     = r_out_sr;
    w_result_nxt     = r_result;
    w_cap_nxt        = r_cap;
    w_captured_nxt   = r_captured;
    w_conv_cnt_nxt   = r_conv_cnt;
    w_sample_req_nxt = r_sample_req;
    w_sample_ch_nxt  = r_sample_ch;
    w_cfg_word_nxt   = r_cfg_word;
    w_cfg_valid_nxt  = 1'b0;
    w_frame_err_nxt  = 1'b0;
    w_dout_nxt       = r_dout;
`ifdef ADC_RAMP_GEN_EN
    w_ramp_nxt       = r_ramp;
`endif

    // cs_n edges take priority over any coincident sclk edge
    if (w_cs_fall) begin
      w_in_frame_nxt = 1'b1;
      w_bit_cnt_nxt  = '0;
      w_out_sr_nxt   = r_result;
      w_dout_nxt     = r_result[RESULT_BITS-1];
      w_stale_nxt    = (r_state == CONV);
      w_frame_err_nxt = (r_state == CONV);
    end else if (w_cs_rise && r_in_frame) begin
      w_in_frame_nxt = 1'b0;
      w_dout_nxt     = 1'b0;
      w_stale_nxt    = 1'b0;
      if (r_bit_cnt < BIT_CNT_W'(CFG_BITS)) begin
        w_frame_err_nxt = 1'b1;
      end else if (!r_stale) begin
        w_cfg_word_nxt  = r_cfg_sr;
        w_cfg_valid_nxt = 1'b1;
        if (!r_cfg_sr[CFG_SLP]) begin
          w_state_nxt     = CONV;
          w_conv_cnt_nxt  = CNT_W'(CONV_CYCLES - 1);
          w_sample_ch_nxt = w_ch;
`ifdef ADC_RAMP_GEN_EN
          w_cap_nxt        = code_of(r_ramp[w_ch], r_cfg_sr[CFG_UNI]);
          w_captured_nxt   = 1'b1;
          w_ramp_nxt[w_ch] = r_ramp[w_ch] + RESULT_BITS'(w_ch) + RESULT_BITS'(1);
`else
          w_sample_req_nxt = 1'b1;
          w_captured_nxt   = 1'b0;
`endif
        end
      end
    end else if (r_in_frame) begin
      if (w_sclk_rise) begin
        if (r_bit_cnt < BIT_CNT_W'(CFG_BITS)) w_cfg_sr_nxt = {r_cfg_sr[CFG_BITS-2:0], w_din};
        if (r_bit_cnt != {BIT_CNT_W{1'b1}}) w_bit_cnt_nxt = r_bit_cnt + BIT_CNT_W'(1);
      end else if (w_sclk_fall) begin
        w_dout_nxt   = r_out_sr[RESULT_BITS-2];
        w_out_sr_nxt = {r_out_sr[RESULT_BITS-2:0], 1'b0};
      end
    end

    // Conversion runs independently of any (stale) frame in progress
    if (r_state == CONV) begin
      if (r_conv_cnt != '0) w_conv_cnt_nxt = r_conv_cnt - CNT_W'(1);
`ifndef ADC_RAMP_GEN_EN
      if (r_sample_req && sample_valid) begin
        w_sample_req_nxt = 1'b0;
        w_cap_nxt        = code_of(sample_in, r_cfg_word[CFG_UNI]);
        w_captured_nxt   = 1'b1;
      end
`endif
      if (r_conv_cnt == '0 && r_captured) begin
        w_state_nxt  = READY;
        w_result_nxt = r_cap;
      end
    end
  end

  assign adc_dout   = r_dout;
  assign sample_req = r_sample_req;
  assign sample_ch  = r_sample_ch;
  assign cfg_word   = r_cfg_word;
  assign cfg_valid  = r_cfg_valid;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_adc_responder.sv
// Randomized self-checking bench for adc_responder against a frame-level model.
module tb_adc_responder;

  localparam int unsigned CONV = 32;
  localparam int unsigned SYNC = 2;
  localparam int          H    = 6;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        adc_cs_n, adc_sclk, adc_din, adc_dout;
  logic        sample_req, sample_valid, cfg_valid, frame_err;
  logic [2:0]  sample_ch;
  logic [11:0] sample_in;
  logic [5:0]  cfg_word;

  adc_responder #(.CONV_CYCLES(CONV), .SYNC_STAGES(SYNC)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .adc_cs_n     (adc_cs_n),
    .adc_sclk     (adc_sclk),
    .adc_din      (adc_din),
    .adc_dout     (adc_dout),
    .sample_req   (sample_req),
    .sample_ch    (sample_ch),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .cfg_word     (cfg_word),
    .cfg_valid    (cfg_valid),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model of the converter
  logic [11:0] m_result, m_pending;
  logic [11:0] m_ramp [8];
  bit          m_conv;
  logic        m_req;
  logic [2:0]  m_ch;
  logic [5:0]  m_cfg;
  int          m_cv, m_err;

  int   o_cv = 0, o_err = 0;
  logic prev_cv = 1'b0, prev_err = 1'b0;
  bit   run_chk = 0, chk_en = 0, idle = 0;

  function automatic logic [11:0] code(input logic [11:0] s, input logic uni);
    return uni ? s : (s ^ 12'h800);
  endfunction

  // Per-cycle comparison of the slowly varying outputs and pulse monitoring
  always @(negedge clk) begin
    if (run_chk) begin
      if (cfg_valid) begin
        o_cv++;
        check("cfg_valid_width", {31'd0, prev_cv}, 32'd0);
      end
      if (frame_err) begin
        o_err++;
        check("frame_err_width", {31'd0, prev_err}, 32'd0);
      end
      prev_cv  = cfg_valid;
      prev_err = frame_err;
      if (chk_en) begin
        check("sample_req", {31'd0, sample_req}, {31'd0, m_req});
        check("sample_ch", {29'd0, sample_ch}, {29'd0, m_ch});
        check("cfg_word", {26'd0, cfg_word}, {26'd0, m_cfg});
      end
      if (idle) check("dout_idle", {31'd0, adc_dout}, 32'd0);
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input logic [5:0] cfg, input int nbits, output logic [11:0] word);
    bit          stale;
    logic [11:0] exp;
    logic        rd, want;
    logic [2:0]  ch;
    stale = m_conv;
    exp   = m_result;
    word  = '0;
    idle  = 0;
    adc_cs_n = 1'b0;
    if (stale) m_err++;
    for (int i = 0; i < nbits; i++) begin
      adc_din = (i < 6) ? cfg[5 - i] : 1'($urandom);
      wait_clk(H);
      adc_sclk = 1'b1;
      wait_clk(H);
      rd   = adc_dout;
      want = (i < 12) ? exp[11 - i] : 1'b0;
      if (i < 12) word[11 - i] = rd;
      check($sformatf("dout_bit%0d", i), {31'd0, rd}, {31'd0, want});
      adc_sclk = 1'b0;
    end
    wait_clk(H);
    chk_en   = 0;
    adc_cs_n = 1'b1;
    wait_clk(8);
    if (nbits < 6) m_err++;
    else if (!stale) begin
      m_cfg = cfg;
      m_cv++;
      if (!cfg[0]) begin
        m_conv = 1;
        ch     = cfg[4:2];
        m_ch   = ch;
`ifdef ADC_RAMP_GEN_EN
        m_pending = code(m_ramp[ch], cfg[1]);
        m_ramp[ch] = m_ramp[ch] + 12'(ch) + 12'd1;
`else
        m_req = 1'b1;
`endif
      end
    end
    check("cfg_valid_count", o_cv, m_cv);
    check("frame_err_count", o_err, m_err);
`ifdef ADC_RAMP_GEN_EN
    if (m_conv) begin
      wait_clk(CONV + 4);
      m_conv   = 0;
      m_result = m_pending;
    end
`endif
    chk_en = 1;
    idle   = 1;
  endtask

  task automatic answer(input logic [11:0] val);
    chk_en = 0;
    wait_clk(1 + $urandom_range(0, 3));
    sample_in    = val;
    sample_valid = 1'b1;
    wait_clk(1);
    sample_valid = 1'b0;
    sample_in    = 12'($urandom);
    m_req     = 1'b0;
    m_pending = code(val, m_cfg[1]);
    check("req_drop", {31'd0, sample_req}, 32'd0);
    wait_clk(CONV + 4);
    m_conv   = 0;
    m_result = m_pending;
    chk_en   = 1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] w;
    logic [5:0]  c;
    int          n;
    reset_n = 1'b0; adc_cs_n = 1'b1; adc_sclk = 1'b0; adc_din = 1'b0;
    sample_valid = 1'b0; sample_in = '0;
    m_result = '0; m_pending = '0; m_conv = 0; m_req = 1'b0; m_ch = '0; m_cfg = '0;
    m_cv = 0; m_err = 0;
    for (int i = 0; i < 8; i++) m_ramp[i] = '0;
    wait_clk(5);
    check("rst_dout", {31'd0, adc_dout}, 32'd0);
    check("rst_req", {31'd0, sample_req}, 32'd0);
    check("rst_cfg_word", {26'd0, cfg_word}, 32'd0);
    reset_n = 1'b1;
    wait_clk(6);
    check("rst_ch", {29'd0, sample_ch}, 32'd0);
    check("rst_cfg_valid", {31'd0, cfg_valid}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    run_chk = 1; chk_en = 1; idle = 1;

`ifdef ADC_RAMP_GEN_EN
    frame(6'b001010, 16, w);
    frame(6'b001010, 16, w);
    check("ramp_r0", {20'd0, w}, 32'h000);
    frame(6'b001010, 16, w);
    check("ramp_r1", {20'd0, w}, 32'h003);
    frame(6'b001010, 16, w);
    check("ramp_r2", {20'd0, w}, 32'h006);
    check("ramp_ch", {29'd0, sample_ch}, 32'd2);
`else
    frame(6'b100010, 16, w);
    check("f1_word", {20'd0, w}, 32'h000);
    check("f1_cfg", {26'd0, cfg_word}, 32'h22);
    check("f1_ch", {29'd0, sample_ch}, 32'd0);
    check("f1_req", {31'd0, sample_req}, 32'd1);
    answer(12'hA5C);
    frame(6'b110000, 16, w);
    check("f2_word", {20'd0, w}, 32'hA5C);
    check("f2_ch", {29'd0, sample_ch}, 32'd4);
    check("f2_cv", o_cv, 32'd2);
    answer(12'h000);
    frame(6'b000011, 16, w);
    check("f3_word", {20'd0, w}, 32'h800);
    check("f3_req_slp", {31'd0, sample_req}, 32'd0);
    frame(6'b000010, 4, w);
    check("short_err", o_err, 32'd1);
    check("short_cv", o_cv, 32'd3);
    check("short_req", {31'd0, sample_req}, 32'd0);
    frame(6'b000110, 16, w);
    check("f5_word", {20'd0, w}, 32'h800);
    frame(6'b111110, 16, w);
    check("stale_word", {20'd0, w}, 32'h800);
    check("stale_err", o_err, 32'd2);
    check("stale_cfg", {26'd0, cfg_word}, 32'h06);
    check("stale_ch", {29'd0, sample_ch}, 32'd1);
    answer(12'h123);
    frame(6'b000011, 16, w);
    check("after_stale_word", {20'd0, w}, 32'h123);
`endif

    for (int it = 0; it < 40; it++) begin
      c = 6'($urandom);
`ifdef ADC_RAMP_GEN_EN
      c[1] = 1'b1;
`endif
      n = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 16);
      frame(c, n, w);
      if (m_req) begin
        if ($urandom_range(0, 3) == 0) begin
          c = 6'($urandom);
          n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 16;
          frame(c, n, w);
        end
        answer(12'($urandom));
      end
    end
    frame(6'b000011, 16, w);

    run_chk = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
